// File: rtl/soc_system_pio_capture_if.sv
// Avalon-MM slave bus bundle for the PIO edge-capture block.
// The master drives the address/strobe/data side; the slave returns readdata.
interface soc_system_pio_capture_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_capture.sv
// Input PIO with a synchroniser, per-bit sticky edge capture, first-edge timestamp
// and a maskable level interrupt, exposed as an Avalon-MM slave.
module soc_system_pio_capture #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int TS_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    soc_system_pio_capture_if.slave bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_TS   = 3'd4;
    localparam logic [2:0] ADDR_CNT  = 3'd5;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [WIDTH-1:0]    edgecap_q, edgecap_d;
    logic [WIDTH-1:0]    irqmask_q, irqmask_d;
    logic [TS_WIDTH-1:0] counter_q, counter_d;
    logic [TS_WIDTH-1:0] timestamp_q, timestamp_d;
    logic [31:0]         readdata_q, readdata_d;
    logic                irq_q, irq_d;

    logic                wr_en;
    logic [WIDTH-1:0]    level;
    logic [WIDTH-1:0]    edge_det;
    logic [WIDTH-1:0]    clr;
    logic [WIDTH-1:0]    kept;

    function automatic logic [31:0] zext_w(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] zext_ts(input logic [TS_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[TS_WIDTH-1:0] = v;
        return r;
    endfunction

    always_comb begin
        wr_en    = bus.chipselect & ~bus.write_n;
        level    = sync_q[SYNC_STAGES-1];
        sync_d   = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d   = level;

        case (EDGE_TYPE)
            0:       edge_det = level & ~prev_q;
            1:       edge_det = ~level & prev_q;
            default: edge_det = level ^ prev_q;
        endcase

        clr = '0;
        if (wr_en && bus.address == ADDR_EDGE) clr = bus.writedata[WIDTH-1:0];
        kept = edgecap_q & ~clr;

        // Set wins over a same-cycle clear, so a fresh edge is never lost.
        edgecap_d = kept | edge_det;

        // Only the first edge into an empty capture register is timestamped.
        timestamp_d = timestamp_q;
        if ((edge_det != '0) && (kept == '0)) timestamp_d = counter_q;

        counter_d = counter_q + TS_WIDTH'(1);
        if (wr_en && bus.address == ADDR_CNT) counter_d = '0;

        irqmask_d = irqmask_q;
        if (wr_en && bus.address == ADDR_MASK) irqmask_d = bus.writedata[WIDTH-1:0];

        irq_d = |(edgecap_q & irqmask_q);

        case (bus.address)
            ADDR_DATA: readdata_d = zext_w(level);
            ADDR_MASK: readdata_d = zext_w(irqmask_q);
            ADDR_EDGE: readdata_d = zext_w(edgecap_q);
            ADDR_TS:   readdata_d = zext_ts(timestamp_q);
            ADDR_CNT:  readdata_d = zext_ts(counter_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            prev_q      <= '0;
            edgecap_q   <= '0;
            irqmask_q   <= '0;
            counter_q   <= '0;
            timestamp_q <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            edgecap_q   <= edgecap_d;
            irqmask_q   <= irqmask_d;
            counter_q   <= counter_d;
            timestamp_q <= timestamp_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_soc_system_pio_capture.sv
// Bench for soc_system_pio_capture: four instances (rising, falling, any-edge, and a
// narrow 8-bit/3-stage variant) driven in parallel and checked against a register-level model.
module tb_soc_system_pio_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [2:0]  t_addr;
    logic        t_cs;
    logic        t_wn;
    logic [31:0] t_wd;
    logic [31:0] t_in;

    int checks = 0;
    int errors = 0;

    localparam int          ET [4] = '{0, 1, 2, 0};
    localparam int          SS [4] = '{2, 2, 2, 3};
    localparam logic [31:0] WM [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
    localparam logic [31:0] TM [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

    soc_system_pio_capture_if b0 ();
    soc_system_pio_capture_if b1 ();
    soc_system_pio_capture_if b2 ();
    soc_system_pio_capture_if b3 ();

    assign b0.address = t_addr; assign b0.chipselect = t_cs; assign b0.write_n = t_wn; assign b0.writedata = t_wd;
    assign b1.address = t_addr; assign b1.chipselect = t_cs; assign b1.write_n = t_wn; assign b1.writedata = t_wd;
    assign b2.address = t_addr; assign b2.chipselect = t_cs; assign b2.write_n = t_wn; assign b2.writedata = t_wd;
    assign b3.address = t_addr; assign b3.chipselect = t_cs; assign b3.write_n = t_wn; assign b3.writedata = t_wd;

    logic [31:0] rd [4];
    logic [3:0]  irqs;
    assign rd[0] = b0.readdata;
    assign rd[1] = b1.readdata;
    assign rd[2] = b2.readdata;
    assign rd[3] = b3.readdata;

    soc_system_pio_capture #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .TS_WIDTH(32)) u_rise (
        .clk(clk), .reset_n(reset_n), .bus(b0.slave), .in_port(t_in), .irq(irqs[0]));
    soc_system_pio_capture #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(1), .TS_WIDTH(32)) u_fall (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave), .in_port(t_in), .irq(irqs[1]));
    soc_system_pio_capture #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2), .TS_WIDTH(32)) u_any (
        .clk(clk), .reset_n(reset_n), .bus(b2.slave), .in_port(t_in), .irq(irqs[2]));
    soc_system_pio_capture #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(0), .TS_WIDTH(8)) u_narrow (
        .clk(clk), .reset_n(reset_n), .bus(b3.slave), .in_port(t_in[7:0]), .irq(irqs[3]));

    // Reference model: the level software sees is in_port delayed by SYNC_STAGES clocks;
    // registers follow the register-map rules directly.
    logic [31:0] m_hist [4][5];
    logic [31:0] m_ec [4], m_mask [4], m_cnt [4], m_ts [4], m_rd [4];
    logic        m_irq [4];
    logic [31:0] n_ec [4], n_mask [4], n_cnt [4], n_ts [4], n_rd [4];
    logic        n_irq [4];
    logic [31:0] lv [4], pv [4], ed [4], cl [4];
    logic        m_wr;

    always_comb begin
        m_wr = t_cs && !t_wn;
        for (int e = 0; e < 4; e++) begin
            lv[e] = m_hist[e][SS[e]-1];
            pv[e] = m_hist[e][SS[e]];
            case (ET[e])
                0:       ed[e] = lv[e] & ~pv[e];
                1:       ed[e] = ~lv[e] & pv[e];
                default: ed[e] = lv[e] ^ pv[e];
            endcase
            cl[e] = (m_wr && t_addr == 3'd3) ? (t_wd & WM[e]) : 32'h0;
            case (t_addr)
                3'd0:    n_rd[e] = lv[e];
                3'd2:    n_rd[e] = m_mask[e];
                3'd3:    n_rd[e] = m_ec[e];
                3'd4:    n_rd[e] = m_ts[e];
                3'd5:    n_rd[e] = m_cnt[e];
                default: n_rd[e] = 32'h0;
            endcase
            n_ec[e]   = (m_ec[e] & ~cl[e]) | ed[e];
            n_ts[e]   = (ed[e] != 0 && (m_ec[e] & ~cl[e]) == 0) ? m_cnt[e] : m_ts[e];
            n_cnt[e]  = (m_wr && t_addr == 3'd5) ? 32'h0 : ((m_cnt[e] + 32'd1) & TM[e]);
            n_mask[e] = (m_wr && t_addr == 3'd2) ? (t_wd & WM[e]) : m_mask[e];
            n_irq[e]  = |(m_ec[e] & m_mask[e]);
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < 4; e++) begin
                for (int k = 0; k < 5; k++) m_hist[e][k] <= 32'h0;
                m_ec[e] <= 0; m_mask[e] <= 0; m_cnt[e] <= 0; m_ts[e] <= 0; m_rd[e] <= 0; m_irq[e] <= 0;
            end
        end else begin
            for (int e = 0; e < 4; e++) begin
                m_hist[e][0] <= t_in & WM[e];
                for (int k = 1; k < 5; k++) m_hist[e][k] <= m_hist[e][k-1];
                m_ec[e] <= n_ec[e]; m_mask[e] <= n_mask[e]; m_cnt[e] <= n_cnt[e];
                m_ts[e] <= n_ts[e]; m_rd[e] <= n_rd[e]; m_irq[e] <= n_irq[e];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        t_addr = a; t_cs = 1'b1; t_wn = 1'b0; t_wd = d;
        @(negedge clk);
        t_cs = 1'b0; t_wn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_ec [4];
        exp_ec = '{32'hFF, 32'h0, 32'hFF, 32'hFF};
        reset_n = 1'b0; t_in = 32'hFF; t_addr = 3'd0; t_cs = 1'b0; t_wn = 1'b1; t_wd = 32'h0;
        tick(3);
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (rd[e] !== 32'h0) begin errors++; $display("FAIL reset_readdata dut%0d: got %h want 0", e, rd[e]); end
            checks++;
            if (irqs[e] !== 1'b0) begin errors++; $display("FAIL reset_irq dut%0d: got %b want 0", e, irqs[e]); end
        end
        reset_n = 1'b1;
        tick(6);
        t_addr = 3'd0; tick(1);
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (rd[e] !== 32'hFF) begin errors++; $display("FAIL post_reset_data dut%0d: got %h want ff", e, rd[e]); end
        end
        t_addr = 3'd3; tick(1);
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (rd[e] !== exp_ec[e]) begin errors++; $display("FAIL post_reset_edge dut%0d: got %h want %h", e, rd[e], exp_ec[e]); end
        end
        bus_write(3'd3, 32'hFFFF_FFFF);
    endtask

    task automatic test_rising();
        t_in = 32'h0; tick(6);
        bus_write(3'd3, 32'hFFFF_FFFF);
        t_addr = 3'd3; tick(2);
        t_in = 32'h20;
        tick(3);
        checks++;
        if (rd[0] !== 32'h0) begin errors++; $display("FAIL rise_early: got %h want 0", rd[0]); end
        tick(1);
        checks++;
        if (rd[0] !== 32'h20) begin errors++; $display("FAIL rise_latency: got %h want 20", rd[0]); end
        checks++;
        if (rd[3] !== 32'h0) begin errors++; $display("FAIL rise_narrow_early: got %h want 0", rd[3]); end
        tick(1);
        checks++;
        if (rd[3] !== 32'h20) begin errors++; $display("FAIL rise_narrow_latency: got %h want 20", rd[3]); end
        checks++;
        if (rd[1] !== 32'h0) begin errors++; $display("FAIL fall_on_rise: got %h want 0", rd[1]); end
        checks++;
        if (rd[2] !== 32'h20) begin errors++; $display("FAIL any_on_rise: got %h want 20", rd[2]); end
        t_in = 32'h0; tick(6);
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (rd[e] !== 32'h20) begin errors++; $display("FAIL after_fall dut%0d: got %h want 20", e, rd[e]); end
        end
    endtask

    task automatic test_any_edge();
        bus_write(3'd3, 32'hFFFF_FFFF);
        t_addr = 3'd3;
        t_in = 32'h1; tick(5);
        t_in = 32'h0; tick(5);
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (rd[e] !== 32'h1) begin errors++; $display("FAIL toggle_bit0 dut%0d: got %h want 1", e, rd[e]); end
        end
        bus_write(3'd3, 32'h1);
        tick(1);
        checks++;
        if (rd[2] !== 32'h0) begin errors++; $display("FAIL any_w1c: got %h want 0", rd[2]); end
    endtask

    task automatic test_irq();
        bus_write(3'd2, 32'h4);
        bus_write(3'd3, 32'hFFFF_FFFF);
        t_addr = 3'd3;
        tick(1);
        t_in = 32'h4;
        tick(3);
        checks++;
        if (irqs[0] !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irqs[0]); end
        tick(1);
        checks++;
        if (irqs[0] !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b want 1", irqs[0]); end
        checks++;
        if (irqs[1] !== 1'b0) begin errors++; $display("FAIL irq_fall_dut: got %b want 0", irqs[1]); end
        tick(1);
        checks++;
        if (irqs[3] !== 1'b1) begin errors++; $display("FAIL irq_narrow: got %b want 1", irqs[3]); end
        bus_write(3'd3, 32'h4);
        checks++;
        if (irqs[0] !== 1'b1) begin errors++; $display("FAIL irq_hold_on_clear: got %b want 1", irqs[0]); end
        tick(1);
        checks++;
        if (irqs[0] !== 1'b0) begin errors++; $display("FAIL irq_deassert: got %b want 0", irqs[0]); end
        t_in = 32'hC; tick(6);
        checks++;
        if (irqs[0] !== 1'b0) begin errors++; $display("FAIL irq_masked_bit3: got %b want 0", irqs[0]); end
        checks++;
        if (rd[0] !== 32'h8) begin errors++; $display("FAIL bit3_flag: got %h want 8", rd[0]); end
    endtask

    task automatic test_timestamp();
        bus_write(3'd3, 32'hFFFF_FFFF);
        for (int j = 0; j < 35; j++) begin
            case (j)
                0:  begin t_addr = 3'd5; t_cs = 1'b1; t_wn = 1'b0; t_wd = 32'h0; end
                1:  begin t_cs = 1'b0; t_wn = 1'b1; t_addr = 3'd4; end
                9:  t_in = t_in | 32'h10;
                19: t_in = t_in | 32'h20;
                25: begin t_addr = 3'd3; t_cs = 1'b1; t_wn = 1'b0; t_wd = 32'hFFFF_FFFF; end
                26: begin t_cs = 1'b0; t_wn = 1'b1; t_addr = 3'd4; end
                29: t_in = t_in | 32'h40;
                default: ;
            endcase
            if (j == 15 || j == 24) begin
                checks++;
                if (rd[0] !== 32'd10) begin errors++; $display("FAIL ts_first j%0d: got %0d want 10", j, rd[0]); end
                checks++;
                if (rd[2] !== 32'd10) begin errors++; $display("FAIL ts_any j%0d: got %0d want 10", j, rd[2]); end
                checks++;
                if (rd[3] !== 32'd11) begin errors++; $display("FAIL ts_narrow j%0d: got %0d want 11", j, rd[3]); end
            end
            if (j == 34) begin
                checks++;
                if (rd[0] !== 32'd30) begin errors++; $display("FAIL ts_relatch: got %0d want 30", rd[0]); end
                checks++;
                if (rd[3] !== 32'd31) begin errors++; $display("FAIL ts_narrow_relatch: got %0d want 31", rd[3]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_simultaneous();
        t_in = t_in | 32'h2; tick(5);
        t_in = t_in & ~32'h2; tick(5);
        t_in = t_in | 32'h2; tick(2);
        bus_write(3'd3, 32'h2);
        t_addr = 3'd3; tick(1);
        checks++;
        if (rd[0] !== 32'h42) begin errors++; $display("FAIL set_wins_rise: got %h want 42", rd[0]); end
        checks++;
        if (rd[2] !== 32'h42) begin errors++; $display("FAIL set_wins_any: got %h want 42", rd[2]); end
    endtask

    task automatic test_counter_wrap();
        bit found = 1'b0;
        t_addr = 3'd5;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (rd[3] === 32'hFF) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL counter_reach_max: got no ff within 300 cycles, want ff");
        end else begin
            tick(1);
            checks++;
            if (rd[3] !== 32'h0) begin errors++; $display("FAIL counter_wrap: got %h want 0", rd[3]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int e = 0; e < 4; e++) begin
                checks++;
                if (rd[e] !== m_rd[e]) begin
                    errors++; $display("FAIL rand_readdata dut%0d cyc%0d: got %h want %h", e, c, rd[e], m_rd[e]);
                end
                checks++;
                if (irqs[e] !== m_irq[e]) begin
                    errors++; $display("FAIL rand_irq dut%0d cyc%0d: got %b want %b", e, c, irqs[e], m_irq[e]);
                end
            end
            reset_n = !(c >= 200 && c < 202);
            if ($urandom_range(0, 2) == 0) t_in = t_in ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) t_in = t_in ^ ($urandom & 32'hFF);
            t_addr = 3'($urandom_range(0, 7));
            t_cs   = ($urandom_range(0, 3) == 0);
            t_wn   = ($urandom_range(0, 1) == 0);
            t_wd   = $urandom;
            @(negedge clk);
        end
        t_cs = 1'b0; t_wn = 1'b1; reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rising();
        test_any_edge();
        test_irq();
        test_timestamp();
        test_simultaneous();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_system_pio_capture.md
Name: soc_system_pio_capture

Overview:
- Parametrised successor to the read-only input PIO.
- Avalon-MM slave on the HPS lightweight bridge that samples a WIDTH-bit input bus through a synchroniser.
- Detects configurable edges per bit into sticky edge-capture flags, timestamps the first edge with a free-running counter, and raises a maskable interrupt.
- Used for timer/encoder/event inputs where software needs edge history and timing, not just the current level.

Parameters:
- WIDTH, 32: input bus width, 1..32; readdata bits above WIDTH-1 read 0.
- SYNC_STAGES, 2: synchroniser flops on in_port, 2..4.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.
- TS_WIDTH, 32: timestamp counter width, 8..32; zero-extended on read.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word address.
- chipselect  in  1  Avalon chipselect.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  registered active-high interrupt.

Behaviour:
- Reset (async, reset_n low) clears every register: readdata=0, irq=0, sync chain=0, prev=0, edgecapture=0, irqmask=0, counter=0, timestamp=0. Reset mid-operation discards pending edges. The first post-reset sample is compared against prev=0, so a bit that is high at reset release produces a rising edge.
- Register map: 0 data (RO, synchronised level); 2 irqmask (RW, WIDTH bits); 3 edgecapture (R, write-1-to-clear per bit); 4 timestamp (RO); 5 counter (R; any write clears it to 0). Addresses 1, 6, 7 read 0, and writes to them are ignored.
- Read path: readdata <= mux(address) every clk, regardless of chipselect, so read latency is 1 clock. Reads have no side effects.
- Write is accepted when chipselect=1 and write_n=0. It takes effect on that clk edge, with zero wait states.
- Synchroniser: sync[0] <= in_port, sync[i] <= sync[i-1]. prev <= sync[last].
- Edge detect (combinational), per EDGE_TYPE:
  - rising: sync[last] & ~prev
  - falling: ~sync[last] & prev
  - any: sync[last] ^ prev
- Input-to-flag latency: an in_port change is visible in edgecapture SYNC_STAGES+1 clocks later, i.e. 3 clocks at the default.
- edgecapture next = (edgecapture & ~clr) | edge, where clr = writedata[WIDTH-1:0] on a write to address 3, else 0. Set wins over a simultaneous clear on the same bit.
- Counter: increments by 1 every clk and wraps from 2^TS_WIDTH-1 to 0. A write to address 5 loads 0 on that edge, and the counter increments again from the next edge.
- Timestamp: latches the current counter value when (edge != 0) and ((edgecapture & ~clr) == 0), i.e. on the first edge into an empty capture register. Further edges do not update it until all flags are cleared. If an edge coincides with the clear of the last flag, the timestamp re-latches.
- irq <= |(edgecapture & irqmask), registered, so it asserts 1 clk after a flag or mask change and deasserts 1 clk after the clear. irq is a level: it stays high while any unmasked flag is set.
- Width rules: bits of writedata above WIDTH-1 are ignored. Reads of data, irqmask and edgecapture are zero-extended.

Test Plan:
- Reset: hold reset_n=0 with in_port=0x0000_00FF. Required: readdata=0, irq=0. Release reset, then read address 0 → 0x0000_00FF and address 3 → 0x0000_00FF (rising default).
- Rising capture (EDGE_TYPE=0): in_port bit 5 goes 0→1 at cycle t. Required: edgecapture=0x20 at t+3. A falling edge on bit 5 leaves 0x20.
- Any-edge (EDGE_TYPE=2): toggle bit 0 twice, then write 0x1 to address 3. Required: read of address 3 returns 0.
- IRQ: irqmask=0x4, then a rising edge on bit 2. Required: irq=1 one clk after the flag sets. Write 0x4 to address 3 → irq=0 the next clk. An edge on bit 3 alone keeps irq=0.
- Timestamp: clear counter at cycle c, then an edge reaches edge-detect at c+10. Required: timestamp=10. A second edge at c+20 leaves it at 10. Clear all flags, edge at c+30 → timestamp=30.
- Simultaneous: a bit 1 edge in the same clk as a write 0x2 to address 3. Required: bit 1 stays set. Counter at 0xFFFF_FFFF reads 0 on the next clk.
